// File: rtl/aclk_key_entry.sv
// Keypad front end of the alarm clock: collects BCD digits into a four-digit key buffer,
// selects what the display shows, and issues load strobes for the time and alarm registers.
module aclk_key_entry #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] key_ms_hr,
  output logic [3:0] key_ls_hr,
  output logic [3:0] key_ms_min,
  output logic [3:0] key_ls_min,
  output logic       show_new_time,
  output logic       show_a,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       key_error
);

  typedef enum logic [1:0] {StShowTime, StKeyEntry, StShowAlarm} state_e;

  localparam logic [3:0] KeyAlarm = 4'd10;
  localparam logic [3:0] KeyTime  = 4'd11;
  localparam logic [3:0] KeyClear = 4'd12;
  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_SEC);

  state_e      state_q, state_d;
  // Buffer packed as {ms_hr, ls_hr, ms_min, ls_min}.
  logic [15:0] buf_q, buf_d;
  logic [2:0]  count_q, count_d;
  logic [7:0]  timer_q, timer_d;
  logic        load_c_q, load_c_d;
  logic        load_a_q, load_a_d;
  logic        err_q, err_d;
  logic        is_digit;
  logic        accepted;
  logic        commit_ok;

  assign is_digit = (key_code <= 4'd9);

  // Valid time is 00:00..23:59 with all four digits entered.
  assign commit_ok = (count_q == 3'd4) && (buf_q[15:12] <= 4'd2) &&
                     ((buf_q[15:12] < 4'd2) || (buf_q[11:8] <= 4'd3)) &&
                     (buf_q[7:4] <= 4'd5);

  // Next-state logic: key handling first, then the inactivity timer.
  always_comb begin
    state_d  = state_q;
    // The buffer survives the strobe cycle so the consumer can sample it, then clears.
    buf_d    = (load_c_q || load_a_q) ? 16'h0000 : buf_q;
    count_d  = count_q;
    timer_d  = timer_q;
    load_c_d = 1'b0;
    load_a_d = 1'b0;
    err_d    = 1'b0;
    accepted = 1'b0;

    if (key_valid) begin
      case (state_q)
        StShowTime, StShowAlarm: begin
          if (is_digit) begin
            buf_d    = {12'h000, key_code};
            count_d  = 3'd1;
            state_d  = StKeyEntry;
            accepted = 1'b1;
          end else if (key_code == KeyAlarm) begin
            state_d  = (state_q == StShowTime) ? StShowAlarm : StShowTime;
            accepted = 1'b1;
          end
        end
        StKeyEntry: begin
          if (is_digit) begin
            buf_d    = {buf_q[11:0], key_code};
            count_d  = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;
            accepted = 1'b1;
          end else if (key_code == KeyClear) begin
            buf_d    = 16'h0000;
            count_d  = 3'd0;
            accepted = 1'b1;
          end else if (key_code == KeyTime || key_code == KeyAlarm) begin
            accepted = 1'b1;
            if (commit_ok) begin
              load_c_d = (key_code == KeyTime);
              load_a_d = (key_code == KeyAlarm);
              count_d  = 3'd0;
              state_d  = StShowTime;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = StShowTime;
      endcase
    end

    if (accepted || (state_d != state_q)) begin
      timer_d = 8'd0;
    end else if (one_second && (state_q != StShowTime)) begin
      if (timer_q + 8'd1 == TimeoutLimit) begin
        state_d = StShowTime;
        buf_d   = 16'h0000;
        count_d = 3'd0;
        timer_d = 8'd0;
      end else begin
        timer_d = timer_q + 8'd1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StShowTime;
      buf_q    <= 16'h0000;
      count_q  <= 3'd0;
      timer_q  <= 8'd0;
      load_c_q <= 1'b0;
      load_a_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      load_c_q <= load_c_d;
      load_a_q <= load_a_d;
      err_q    <= err_d;
    end
  end

  assign key_ms_hr     = buf_q[15:12];
  assign key_ls_hr     = buf_q[11:8];
  assign key_ms_min    = buf_q[7:4];
  assign key_ls_min    = buf_q[3:0];
  assign show_new_time = (state_q == StKeyEntry);
  assign show_a        = (state_q == StShowAlarm);
  assign load_new_c    = load_c_q;
  assign load_new_a    = load_a_q;
  assign key_error     = err_q;

endmodule

// File: tb/tb_aclk_key_entry.sv
// Bench for aclk_key_entry: directed scenarios plus random key/tick traffic, all checked
// against a decimal-arithmetic reference model of the key entry rules.
module tb_aclk_key_entry;

  localparam int unsigned TO = 3;

  logic       clock;
  logic       reset;
  logic       one_second;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
  logic       show_new_time, show_a, load_new_c, load_new_a, key_error;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 show time, 1 key entry, 2 show alarm; buffer as a decimal 0..9999.
  int m_mode, m_buf, m_cnt, m_timer;
  bit m_lc, m_la, m_err, m_clr;

  aclk_key_entry #(.TIMEOUT_SEC(TO)) dut (
    .clock         (clock),
    .reset         (reset),
    .one_second    (one_second),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .key_ms_hr     (key_ms_hr),
    .key_ls_hr     (key_ls_hr),
    .key_ms_min    (key_ms_min),
    .key_ls_min    (key_ls_min),
    .show_new_time (show_new_time),
    .show_a        (show_a),
    .load_new_c    (load_new_c),
    .load_new_a    (load_new_a),
    .key_error     (key_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_buf = 0; m_cnt = 0; m_timer = 0;
    m_lc = 0; m_la = 0; m_err = 0; m_clr = 0;
  endtask

  task automatic model_edge(input bit kv, input int c, input bit tick);
    int  nmode;
    bit  acc;
    nmode = m_mode;
    acc   = 0;
    if (m_clr) m_buf = 0;
    m_clr = 0; m_lc = 0; m_la = 0; m_err = 0;
    if (kv) begin
      if (m_mode == 1) begin
        if (c <= 9) begin
          m_buf = (m_buf * 10 + c) % 10000;
          m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
          acc = 1;
        end else if (c == 12) begin
          m_buf = 0; m_cnt = 0; acc = 1;
        end else if (c == 10 || c == 11) begin
          acc = 1;
          if (m_cnt == 4 && m_buf / 100 <= 23 && m_buf % 100 <= 59) begin
            if (c == 11) m_lc = 1; else m_la = 1;
            m_cnt = 0; m_clr = 1; nmode = 0;
          end else begin
            m_err = 1;
          end
        end
      end else begin
        if (c <= 9) begin
          m_buf = c; m_cnt = 1; nmode = 1; acc = 1;
        end else if (c == 10) begin
          nmode = (m_mode == 0) ? 2 : 0; acc = 1;
        end
      end
    end
    if (acc || nmode != m_mode) begin
      m_timer = 0;
    end else if (tick && m_mode != 0) begin
      m_timer++;
      if (m_timer == TO) begin
        nmode = 0; m_buf = 0; m_cnt = 0; m_timer = 0;
      end
    end
    m_mode = nmode;
  endtask

  function automatic logic [15:0] exp_bcd();
    return {4'(m_buf / 1000), 4'((m_buf / 100) % 10), 4'((m_buf / 10) % 10), 4'(m_buf % 10)};
  endfunction

  function automatic logic [15:0] dut_bcd();
    return {key_ms_hr, key_ls_hr, key_ms_min, key_ls_min};
  endfunction

  task automatic compare_all();
    check("digits", {16'h0, dut_bcd()}, {16'h0, exp_bcd()});
    check("flags", {27'h0, show_new_time, show_a, load_new_c, load_new_a, key_error},
          {27'h0, m_mode == 1, m_mode == 2, m_lc, m_la, m_err});
  endtask

  // One clock cycle: drive inputs, advance DUT and model on the edge, compare just after.
  task automatic step(input bit kv, input logic [3:0] code, input bit tick);
    key_valid  = kv;
    key_code   = code;
    one_second = tick;
    @(posedge clock);
    model_edge(kv, int'(code), tick);
    #1;
    key_valid  = 1'b0;
    one_second = 1'b0;
    compare_all();
  endtask

  task automatic key(input logic [3:0] code);
    step(1'b1, code, 1'b0);
  endtask

  task automatic tick();
    step(1'b0, 4'd0, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; one_second = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    model_reset();
    #12;
    compare_all();
    @(negedge clock);
    reset = 1'b0;

    // 1234 TIME: strobe with buffer intact, then clears.
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    key(4'd11);
    check("commit_c_buf", {16'h0, dut_bcd()}, 32'h1234);
    check("commit_c_strobe", {31'h0, load_new_c}, 32'h1);
    idle();
    check("commit_c_clear", {16'h0, dut_bcd()}, 32'h0);

    // 2400 ALARM rejected; CLEAR then 2359 ALARM accepted.
    key(4'd2); key(4'd4); key(4'd0); key(4'd0);
    key(4'd10);
    check("reject_2400", {30'h0, key_error, show_new_time}, 32'h3);
    key(4'd12); key(4'd2); key(4'd3); key(4'd5); key(4'd9);
    key(4'd10);
    check("commit_a_buf", {16'h0, dut_bcd()}, 32'h2359);
    check("commit_a_strobe", {31'h0, load_new_a}, 32'h1);
    idle();

    // Too few digits, then completed to 0730.
    key(4'd0); key(4'd7); key(4'd11);
    check("reject_short", {31'h0, key_error}, 32'h1);
    key(4'd3); key(4'd0); key(4'd11);
    check("commit_0730", {16'h0, dut_bcd()}, 32'h0730);
    idle();

    // Overflow shift; key with simultaneous tick keeps the timer at zero.
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    check("shift_2345", {16'h0, dut_bcd()}, 32'h2345);
    step(1'b1, 4'd6, 1'b1);
    check("shift_3456", {16'h0, dut_bcd()}, 32'h3456);
    tick(); tick();
    check("no_early_timeout", {31'h0, show_new_time}, 32'h1);
    tick();
    check("timeout_entry", {15'h0, show_new_time, dut_bcd()}, 32'h0);

    // Ignored code 14 does not reset the timer; ALARM view times out.
    key(4'd10);
    tick(); key(4'd14); tick();
    check("alarm_shown", {31'h0, show_a}, 32'h1);
    tick();
    check("timeout_alarm", {31'h0, show_a}, 32'h0);

    // Asynchronous reset mid-entry.
    key(4'd1); key(4'd2);
    #2 reset = 1'b1;
    #1;
    check("async_reset", {11'h0, dut_bcd(), show_new_time, show_a, load_new_c, load_new_a,
          key_error}, 32'h0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    idle(); idle();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      logic [3:0] c;
      if ($urandom_range(0, 9) < 6) c = 4'($urandom_range(0, 9));
      else c = 4'($urandom_range(10, 15));
      step(1'($urandom_range(0, 1)), c, $urandom_range(0, 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
